uart_sample_tx: RTL and testbench

UART transmitter that serialises 16-bit audio samples as two 8N1 frames, LSB byte first, then MSB byte. It is the transmit-side counterpart of the sample receiver, using the same bit timing and byte order so that loopback reconstructs identical samples. It has a one-deep holding register so an upstream sample source can queue the next sample while the current one is on the wire.

---
 rtl/uart_sample_tx.sv | 136 +++++++++++++
 tb/tb_uart_sample_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sample_tx.sv
// 16-bit sample UART transmitter: two 8N1 frames per sample, LSB byte first.
// One-deep holding register lets the source queue the next sample mid-frame.
module uart_sample_tx #(
  parameter int DELAY_FRAMES = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        uart_tx,
  output logic        busy,
  output logic        tx_done
);

  localparam int CW = $clog2(DELAY_FRAMES);
  localparam logic [CW-1:0] LAST = CW'(DELAY_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic          phase, phase_n;
  logic [15:0]   shift, shift_n;
  logic [15:0]   hold, hold_n;
  logic          hold_full, hold_full_n;
  logic [7:0]    byte_n;
  logic          take, load, last;
  logic          tx_n, done_n;

  always_comb begin
    take    = sample_valid && sample_ready;
    last    = (cnt == LAST);
    load    = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    phase_n = phase;
    shift_n = shift;

    unique case (state)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          state_n = START;
          cnt_n   = '0;
          phase_n = 1'b0;
        end
      end
      START: begin
        cnt_n = cnt + 1'b1;
        if (last) begin
          state_n = DATA;
          cnt_n   = '0;
          bit_n   = '0;
        end
      end
      DATA: begin
        cnt_n = cnt + 1'b1;
        if (last) begin
          cnt_n = '0;
          bit_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        cnt_n = cnt + 1'b1;
        if (last) begin
          cnt_n = '0;
          if (!phase) begin
            phase_n = 1'b1;
            state_n = START;
          end else if (hold_full) begin
            load    = 1'b1;
            phase_n = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) shift_n = hold;
    hold_n      = take ? sample_in : hold;
    hold_full_n = take | (hold_full & ~load);

    // Line level is derived from the next state so the flop tracks the FSM.
    byte_n = phase_n ? shift_n[15:8] : shift_n[7:0];
    tx_n   = 1'b1;
    unique case (1'b1)
      (state_n == START): tx_n = 1'b0;
      (state_n == DATA):  tx_n = byte_n[bit_n];
      default:            tx_n = 1'b1;
    endcase

    done_n = (state_n == STOP) && phase_n && (cnt_n == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      phase        <= 1'b0;
      shift        <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      sample_ready <= 1'b0;
      uart_tx      <= 1'b1;
      tx_done      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_n;
      phase        <= phase_n;
      shift        <= shift_n;
      hold         <= hold_n;
      hold_full    <= hold_full_n;
      sample_ready <= ~hold_full_n;
      uart_tx      <= tx_n;
      tx_done      <= done_n;
    end
  end

  assign busy = (state != IDLE) || hold_full;

endmodule

// File: tb/tb_uart_sample_tx.sv
// Directed bench for uart_sample_tx: waveform, back-to-back, stall,
// mid-frame reset and a loopback through a behavioural receiver.
module tb_uart_sample_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] s_in0, s_in1;
  logic        s_valid0, s_valid1;
  logic        s_ready0, s_ready1;
  logic        tx0, tx1;
  logic        busy0, busy1;
  logic        done0, done1;

  int checks = 0;
  int errors = 0;

  uart_sample_tx #(.DELAY_FRAMES(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .sample_in(s_in0), .sample_valid(s_valid0),
    .sample_ready(s_ready0), .uart_tx(tx0),
    .busy(busy0), .tx_done(done0)
  );

  uart_sample_tx #(.DELAY_FRAMES(31)) u1 (
    .clk(clk), .rst_n(rst_n),
    .sample_in(s_in1), .sample_valid(s_valid1),
    .sample_ready(s_ready1), .uart_tx(tx1),
    .busy(busy1), .tx_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] from_str(input string s);
    logic [19:0] f;
    f = '0;
    for (int i = 0; i < 20; i++) f[i] = (s[i] == 8'h31);
    return f;
  endfunction

  // f[0] is the first level on the line
  function automatic logic [19:0] frame(input logic [15:0] d);
    logic [19:0] f;
    f[0]     = 1'b0;
    f[8:1]   = d[7:0];
    f[9]     = 1'b1;
    f[10]    = 1'b0;
    f[18:11] = d[15:8];
    f[19]    = 1'b1;
    return f;
  endfunction

  function automatic logic [79:0] expand(input logic [19:0] f);
    logic [79:0] e;
    for (int k = 0; k < 20; k++)
      for (int j = 0; j < 4; j++) e[4*k+j] = f[k];
    return e;
  endfunction

  task automatic push(input bit sel, input logic [15:0] d);
    int n;
    n = 0;
    if (sel) begin
      s_in1 = d;
      s_valid1 = 1'b1;
      while (!s_ready1 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      s_valid1 = 1'b0;
      chk("hs_wait1", (n < 3000), 1);
      chk("ready_after_hs1", s_ready1, 0);
    end else begin
      s_in0 = d;
      s_valid0 = 1'b1;
      while (!s_ready0 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      s_valid0 = 1'b0;
      chk("hs_wait0", (n < 3000), 1);
      chk("ready_after_hs0", s_ready0, 0);
    end
  endtask

  task automatic capture(input int n,
                         output logic [159:0] w,
                         output logic [159:0] dm,
                         output int waited);
    waited = 0;
    while (tx0 !== 1'b0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("start_seen", tx0, 0);
    w  = '0;
    dm = '0;
    for (int i = 0; i < n; i++) begin
      w[i]  = tx0;
      dm[i] = done0;
      if (i < n - 1) @(negedge clk);
    end
  endtask

  int done0_cnt = 0;
  int done1_cnt = 0;
  always @(negedge clk) begin
    if (done0 === 1'b1) done0_cnt++;
    if (done1 === 1'b1) done1_cnt++;
  end

  // behavioural receiver on the DELAY_FRAMES=31 line, mid-bit sampling
  logic [15:0] rx_q[$];
  int          rx_stop_err = 0;
  initial begin
    logic [7:0] b, lo;
    bit ph;
    ph = 1'b0;
    lo = '0;
    b  = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx1 === 1'b0) begin
        repeat (15) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (31) @(negedge clk);
          b[k] = tx1;
        end
        repeat (31) @(negedge clk);
        if (tx1 !== 1'b1) rx_stop_err++;
        if (!ph) lo = b;
        else rx_q.push_back({b, lo});
        ph = ~ph;
      end
    end
  end

  logic [159:0] w, dm, e, em;
  int           waited, d_before, bad, n;
  logic [15:0]  sent[$];
  logic [15:0]  d;

  initial begin
    rst_n = 1'b0;
    s_in0 = '0;
    s_in1 = '0;
    s_valid0 = 1'b0;
    s_valid1 = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_tx", tx0, 1);
    chk("rst_ready", s_ready0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", s_ready0, 1);

    // single sample 0x12A5
    push(0, 16'h12A5);
    chk("held_tx_idle", tx0, 1);
    chk("held_busy", busy0, 1);
    capture(80, w, dm, waited);
    chk("start_latency", waited, 1);
    e = '0;
    e[79:0] = expand(from_str("01010010110010010001"));
    chk("wave_12a5", w, e);
    em = '0;
    em[79] = 1'b1;
    chk("done_12a5", dm, em);
    @(negedge clk);
    chk("idle_tx", tx0, 1);
    chk("idle_busy", busy0, 0);
    chk("idle_ready", s_ready0, 1);

    // back-to-back 0x8000, 0x7FFF
    fork
      capture(160, w, dm, waited);
      begin
        push(0, 16'h8000);
        push(0, 16'h7FFF);
      end
    join
    e = {expand(frame(16'h7FFF)), expand(frame(16'h8000))};
    chk("wave_b2b", w, e);
    em = '0;
    em[79] = 1'b1;
    em[159] = 1'b1;
    chk("done_b2b", dm, em);
    @(negedge clk);
    chk("b2b_idle_tx", tx0, 1);
    chk("b2b_idle_busy", busy0, 0);

    // stall with full holding register
    fork
      capture(160, w, dm, waited);
      begin
        push(0, 16'h5A3C);
        push(0, 16'hC0DE);
        s_valid0 = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
          s_in0 = 16'($urandom);
          @(negedge clk);
          if (s_ready0) bad++;
        end
        s_valid0 = 1'b0;
        chk("stall_ready", bad, 0);
      end
    join
    e = {expand(frame(16'hC0DE)), expand(frame(16'h5A3C))};
    chk("wave_stall", w, e);
    @(negedge clk);
    chk("stall_idle_busy", busy0, 0);

    // reset during MSB data bit 3
    push(0, 16'h00FF);
    n = 0;
    while (tx0 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    push(0, 16'hBEEF);
    repeat (56) @(negedge clk);
    chk("pre_rst_line", tx0, 0);
    d_before = done0_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx0, 1);
    chk("abort_busy", busy0, 0);
    chk("abort_ready", s_ready0, 0);
    chk("abort_done", done0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_rel", s_ready0, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy0 !== 1'b0 || tx0 !== 1'b1) bad++;
    end
    chk("abort_discard", bad, 0);
    chk("abort_no_done", done0_cnt - d_before, 0);
    push(0, 16'h0001);
    capture(80, w, dm, waited);
    e = '0;
    e[79:0] = expand(frame(16'h0001));
    chk("wave_0001", w, e);
    chk("done_0001", dm[79], 1);

    // loopback at DELAY_FRAMES=31
    for (int i = 0; i < 100; i++) begin
      d = 16'($urandom);
      sent.push_back(d);
      push(1, d);
    end
    n = 0;
    while (rx_q.size() < 100 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_count", rx_q.size(), 100);
    for (int i = 0; i < 100 && i < rx_q.size(); i++)
      chk("loop_data", rx_q[i], sent[i]);
    repeat (40) @(negedge clk);
    chk("loop_done_cnt", done1_cnt, rx_q.size());
    chk("loop_stop_bits", rx_stop_err, 0);
    chk("loop_idle_busy", busy1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
